// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed N-digit 7-segment scanner with dead-time,
// leading-zero blanking and a frame-synchronous shadow buffer for tear-free updates.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_DIV    = 25000,
  parameter int DEAD_CYC    = 250,
  parameter int AN_ACT_LOW  = 1,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      lz_en,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data_i,
  input  logic [NUM_DIGITS-1:0]     dp_i,
  output logic                      pending,
  output logic                      frame_done,
  output logic [NUM_DIGITS-1:0]     AN,
  output logic [7:0]                seg
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W:0]   DEAD_L   = (CNT_W + 1)'(DEAD_CYC);
  localparam logic             AN_INV   = (AN_ACT_LOW != 0);
  localparam logic             SEG_INV  = (SEG_ACT_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_INV}};
  localparam logic [7:0]            SEG_OFF = {8{SEG_INV}};

  typedef enum logic {PH_BLANK, PH_DRIVE} phase_t;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d, shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d, shadow_dp_q, shadow_dp_d;
  logic                    pending_q, pending_d;
  logic                    frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;

  phase_t                  phase;
  logic                    wrap, commit, upper_zero;
  logic [NUM_DIGITS-1:0]   an_lit, lz_blank;
  logic [7:0]              seg_lit;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'b1111110;
      4'h1: hex_glyph = 7'b0110000;
      4'h2: hex_glyph = 7'b1101101;
      4'h3: hex_glyph = 7'b1111001;
      4'h4: hex_glyph = 7'b0110011;
      4'h5: hex_glyph = 7'b1011011;
      4'h6: hex_glyph = 7'b1011111;
      4'h7: hex_glyph = 7'b1110000;
      4'h8: hex_glyph = 7'b1111111;
      4'h9: hex_glyph = 7'b1111011;
      4'hA: hex_glyph = 7'b1110111;
      4'hB: hex_glyph = 7'b0011111;
      4'hC: hex_glyph = 7'b1001110;
      4'hD: hex_glyph = 7'b0111101;
      4'hE: hex_glyph = 7'b1001111;
      default: hex_glyph = 7'b1000111;
    endcase
  endfunction

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    disp_d       = disp_q;
    disp_dp_d    = disp_dp_q;
    shadow_d     = shadow_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;

    wrap   = en && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    // With scanning halted every edge acts as a commit point.
    commit = !en || wrap;
    frame_done_d = wrap;

    if (!en) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (commit) begin
      if (load) begin
        disp_d    = data_i;
        disp_dp_d = dp_i;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        disp_dp_d = shadow_dp_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      shadow_d    = data_i;
      shadow_dp_d = dp_i;
      pending_d   = 1'b1;
    end

    phase = ({1'b0, cnt_q} < DEAD_L) ? PH_BLANK : PH_DRIVE;

    // Walk from the most significant digit down, tracking whether all higher nibbles are zero.
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero  = upper_zero && (disp_q[k*4 +: 4] == 4'h0);
      lz_blank[k] = lz_en && upper_zero && (k != 0) && !disp_dp_q[k];
    end

    an_lit    = '0;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        an_lit[k] = 1'b1;
        cur_nib   = disp_q[k*4 +: 4];
        cur_dp    = disp_dp_q[k];
        cur_blank = lz_blank[k];
      end
    end

    seg_lit = '0;
    if (en && phase == PH_DRIVE) begin
      if (!cur_blank) seg_lit = {hex_glyph(cur_nib), cur_dp};
    end else begin
      an_lit = '0;
    end

    an_d  = an_lit ^ AN_OFF;
    seg_d = seg_lit ^ SEG_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign pending    = pending_q;
  assign frame_done = frame_done_q;
  assign AN         = an_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl (4 digits, 8-cycle slots,
// 2 dead cycles, active-low pins) against a frame-position reference model.
module tb_seg7_scan_ctrl;

  logic        clk, rst_n, en, lz_en, load;
  logic [15:0] data_i;
  logic [3:0]  dp_i;
  logic        pending, frame_done;
  logic [3:0]  AN;
  logic [7:0]  seg;

  int total = 0;
  int bad   = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYC(2), .AN_ACT_LOW(1), .SEG_ACT_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .lz_en(lz_en), .load(load),
    .data_i(data_i), .dp_i(dp_i), .pending(pending), .frame_done(frame_done),
    .AN(AN), .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Model: position within the 32-cycle frame, displayed/shadow words and flags.
  int          m_pos;
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_dp, m_sdp;
  logic        m_pending;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;
  logic        exp_fd;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_disp = '0; m_shadow = '0; m_dp = '0; m_sdp = '0; m_pending = 1'b0;
    exp_an = 4'hF; exp_seg = 8'hFF; exp_fd = 1'b0;
  endtask

  task automatic model_commit();
    if (load) begin
      m_disp = data_i; m_dp = dp_i; m_pending = 1'b0;
    end else if (m_pending) begin
      m_disp = m_shadow; m_dp = m_sdp; m_pending = 1'b0;
    end
  endtask

  task automatic tick();
    int slot, off;
    logic [3:0] nib;
    logic [7:0] lit;
    logic blanked;
    @(posedge clk);
    if (!en) begin
      exp_an = 4'hF; exp_seg = 8'hFF; exp_fd = 1'b0;
      model_commit();
      m_pos = 0;
    end else begin
      slot = m_pos / 8;
      off  = m_pos % 8;
      if (off < 2) begin
        exp_an = 4'hF; exp_seg = 8'hFF;
      end else begin
        exp_an  = ~(4'b0001 << slot);
        nib     = m_disp[slot*4 +: 4];
        blanked = lz_en && (slot > 0) && ((m_disp >> (slot*4)) == 16'h0) && !m_dp[slot];
        lit     = blanked ? 8'h00 : {glyph_tab[nib], m_dp[slot]};
        exp_seg = ~lit;
      end
      exp_fd = (m_pos == 31);
      if (m_pos == 31) model_commit();
      else if (load) begin
        m_shadow = data_i; m_sdp = dp_i; m_pending = 1'b1;
      end
      m_pos = (m_pos + 1) % 32;
    end
    #1;
    load = 1'b0;
    check("AN", 16'(AN), 16'(exp_an));
    check("seg", 16'(seg), 16'(exp_seg));
    check("pending", 16'(pending), 16'(m_pending));
    check("frame_done", 16'(frame_done), 16'(exp_fd));
  endtask

  task automatic run_to(input int p);
    int guard = 0;
    while (m_pos != p && guard < 64) begin
      tick();
      guard++;
    end
    check("run_to", 16'(m_pos), 16'(p));
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    data_i = d; dp_i = p; load = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; lz_en = 1'b0; load = 1'b0; data_i = '0; dp_i = '0;
    model_reset();
    #12;
    check("rst_AN", 16'(AN), 16'h000F);
    check("rst_seg", 16'(seg), 16'h00FF);
    check("rst_pending", 16'(pending), 16'h0);
    check("rst_frame_done", 16'(frame_done), 16'h0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;

    repeat (40) tick();

    run_to(5);
    do_load(16'h12AF, 4'h0);
    run_to(0);
    repeat (32) tick();

    lz_en = 1'b1;
    run_to(10);
    do_load(16'h0030, 4'h0);
    repeat (70) tick();
    do_load(16'h0000, 4'b0100);
    repeat (70) tick();

    lz_en = 1'b0;
    run_to(31);
    do_load(16'hBEEF, 4'h0);
    repeat (64) tick();

    run_to(21);
    en = 1'b0;
    repeat (3) tick();
    do_load(16'h5A5A, 4'b1001);
    repeat (3) tick();
    en = 1'b1;
    repeat (40) tick();

    run_to(4);
    do_load(16'h1357, 4'h0);
    run_to(12);
    #2 rst_n = 1'b0;
    #1;
    check("arst_AN", 16'(AN), 16'h000F);
    check("arst_seg", 16'(seg), 16'h00FF);
    check("arst_pending", 16'(pending), 16'h0);
    check("arst_frame_done", 16'(frame_done), 16'h0);
    model_reset();
    #2 rst_n = 1'b1;
    repeat (40) tick();

    repeat (900) begin
      if ($urandom_range(0, 11) == 0) begin
        data_i = 16'($urandom);
        if ($urandom_range(0, 1) == 0) data_i = data_i & 16'h00FF;
        dp_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        load = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 59) == 0) en = ~en;
      if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
